// File: rtl/md_issue_ctrl_if.sv
// Request channel from E-stage decode into the md issue controller.
// master = E stage, slave = md_issue_ctrl.
interface md_issue_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;

    modport master (output req_valid, req_op, req_a, req_b, input req_ready);
    modport slave  (input req_valid, req_op, req_a, req_b, output req_ready);
endinterface

// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue controller: accepts md ops, pulses md_start, times latency, drives stall.
// Optional one-entry issue queue enabled by defining MD_QUEUE_EN.
//
// state | meaning
// IDLE  | no op in flight, requests issue directly
// RUN   | op in flight, cnt counting down to md_done
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int MT_LAT  = 1
) (
    input  logic           clk,
    input  logic           reset,
    md_issue_ctrl_if.slave req,
    input  logic           hilo_rd,
    input  logic           flush,
    output logic           md_start,
    output logic [2:0]     md_op,
    output logic [31:0]    md_a,
    output logic [31:0]    md_b,
    output logic           md_busy,
    output logic           md_done,
    output logic           stall
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? ((MUL_LAT > MT_LAT) ? MUL_LAT : MT_LAT)
                                                 : ((DIV_LAT > MT_LAT) ? DIV_LAT : MT_LAT);
    localparam int CNT_W = (MAX_LAT > 15) ? $clog2(MAX_LAT) : 4;

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] MT_LD  = CNT_W'(MT_LAT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ready_en;
    logic             accept;
    logic             legal;
    logic             issue_req;
    logic             issue_any;
    logic             q_valid;
    logic [2:0]       iss_op;
    logic [31:0]      iss_a;
    logic [31:0]      iss_b;

    function automatic logic [CNT_W-1:0] load_val(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return MUL_LD;
            3'd2, 3'd3: return DIV_LD;
            default:    return MT_LD;
        endcase
    endfunction

    assign md_busy = (state == RUN);
    assign accept  = req.req_valid & req.req_ready;
    assign legal   = (req.req_op <= 3'd5);
    // md_done only occurs in RUN, so it marks the one RUN cycle where a new op may issue
    assign issue_req = accept & legal & ((state == IDLE) | md_done);

`ifdef MD_QUEUE_EN
    logic        issue_q;
    logic [2:0]  q_op;
    logic [31:0] q_a;
    logic [31:0] q_b;

    assign req.req_ready = ready_en & ~flush & ((state == IDLE) | ~q_valid);
    assign issue_q       = md_done & q_valid & ~flush;
    assign issue_any     = issue_req | issue_q;

    always_comb begin
        iss_op = req.req_op;
        iss_a  = req.req_a;
        iss_b  = req.req_b;
        if (issue_q) begin
            iss_op = q_op;
            iss_a  = q_a;
            iss_b  = q_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid <= 1'b0;
            q_op    <= 3'd0;
            q_a     <= 32'd0;
            q_b     <= 32'd0;
        end else if (flush || issue_q) begin
            q_valid <= 1'b0;
        end else if (accept && legal && state == RUN && !md_done) begin
            q_valid <= 1'b1;
            q_op    <= req.req_op;
            q_a     <= req.req_a;
            q_b     <= req.req_b;
        end
    end
`else
    assign q_valid       = 1'b0;
    assign req.req_ready = ready_en & ~flush & (state == IDLE);
    assign issue_any     = issue_req;

    always_comb begin
        iss_op = req.req_op;
        iss_a  = req.req_a;
        iss_b  = req.req_b;
    end
`endif

    // Gated so nothing is asserted while reset is held
    assign stall = ready_en & ((hilo_rd & (md_busy | md_start | q_valid))
                             | (req.req_valid & ~req.req_ready & ~flush));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_en <= 1'b0;
            md_start <= 1'b0;
            md_done  <= 1'b0;
            md_op    <= 3'd0;
            md_a     <= 32'd0;
            md_b     <= 32'd0;
        end else begin
            ready_en <= 1'b1;
            md_start <= 1'b0;
            md_done  <= 1'b0;
            if (issue_any) begin
                md_start <= 1'b1;
                md_op    <= iss_op;
                md_a     <= iss_a;
                md_b     <= iss_b;
                cnt      <= load_val(iss_op);
                state    <= RUN;
            end else if (state == RUN) begin
                if (md_done) begin
                    state <= IDLE;
                end else if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    md_done <= 1'b1;
                end
            end
        end
    end
endmodule
